// File: rtl/vga_timing_param.sv
// Parametrised VGA raster timing generator with pixel-clock enable,
// run/stop control (stop is deferred to the end of the current frame),
// data enable and line/frame start strobes. All outputs are registered
// and decoded from the next counter values so they stay coherent.
module vga_timing_param #(
    parameter int H_ACTIVE  = 800,
    parameter int H_FP      = 40,
    parameter int H_SYNC    = 128,
    parameter int H_BP      = 88,
    parameter int V_ACTIVE  = 600,
    parameter int V_FP      = 1,
    parameter int V_SYNC    = 4,
    parameter int V_BP      = 23,
    parameter bit HSYNC_POL = 1'b1,
    parameter bit VSYNC_POL = 1'b1,
    parameter int CW        = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic          en,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic          hsync,
    output logic          vsync,
    output logic          hblnk,
    output logic          vblnk,
    output logic          de,
    output logic          line_start,
    output logic          frame_start,
    output logic          running
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOT - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOT - 1);
    localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] H_SS     = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SE     = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] V_SS     = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SE     = CW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RUN       = 2'd1,
        S_STOP_PEND = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] h_q, h_d, v_q, v_d;
    logic          hsync_q, hsync_d, vsync_q, vsync_d;
    logic          hblnk_q, hblnk_d, vblnk_q, vblnk_d;
    logic          de_q, de_d, ls_q, ls_d, fs_q, fs_d, run_q, run_d;

    logic          h_wrap, v_wrap, advance;
    logic [CW-1:0] h_inc, v_inc;

    // Next-state, next counters and decoded flags; with ce=0 the state and
    // counters hold, so the decode reproduces the held flag values.
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        ls_d    = 1'b0;
        fs_d    = 1'b0;
        advance = 1'b0;

        h_wrap  = (h_q == H_LAST);
        v_wrap  = (v_q == V_LAST);
        h_inc   = h_wrap ? '0 : h_q + ONE;
        v_inc   = h_wrap ? (v_wrap ? '0 : v_q + ONE) : v_q;

        if (ce) begin
            unique case (state_q)
                S_IDLE: begin
                    // Start at (0,0) immediately so the first pixel is visible next clk.
                    if (en) begin
                        state_d = S_RUN;
                        h_d     = '0;
                        v_d     = '0;
                        ls_d    = 1'b1;
                        fs_d    = 1'b1;
                    end
                end
                S_RUN: begin
                    advance = 1'b1;
                    if (!en) state_d = S_STOP_PEND;
                end
                S_STOP_PEND: begin
                    if (en) begin
                        state_d = S_RUN;
                        advance = 1'b1;
                    end else if (h_wrap && v_wrap) begin
                        // End of frame reached while stopping: park silently.
                        state_d = S_IDLE;
                        h_d     = '0;
                        v_d     = '0;
                    end else begin
                        advance = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (advance) begin
            h_d  = h_inc;
            v_d  = v_inc;
            ls_d = h_wrap;
            fs_d = h_wrap && v_wrap;
        end

        run_d = (state_d != S_IDLE);
        if (run_d) begin
            hblnk_d = (h_d >= H_ACT_C);
            vblnk_d = (v_d >= V_ACT_C);
            hsync_d = ((h_d >= H_SS) && (h_d < H_SE)) ? HSYNC_POL : ~HSYNC_POL;
            vsync_d = ((v_d >= V_SS) && (v_d < V_SE)) ? VSYNC_POL : ~VSYNC_POL;
        end else begin
            hblnk_d = 1'b1;
            vblnk_d = 1'b1;
            hsync_d = ~HSYNC_POL;
            vsync_d = ~VSYNC_POL;
        end
        de_d = !hblnk_d && !vblnk_d && run_d;
    end

    // State, counters and all output flags are registered together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            h_q     <= '0;
            v_q     <= '0;
            hsync_q <= ~HSYNC_POL;
            vsync_q <= ~VSYNC_POL;
            hblnk_q <= 1'b1;
            vblnk_q <= 1'b1;
            de_q    <= 1'b0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            hblnk_q <= hblnk_d;
            vblnk_q <= vblnk_d;
            de_q    <= de_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
            run_q   <= run_d;
        end
    end

    assign hcount      = h_q;
    assign vcount      = v_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign hblnk       = hblnk_q;
    assign vblnk       = vblnk_q;
    assign de          = de_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign running     = run_q;

endmodule
